single_port_sync_ram_lg: RTL and testbench

//  Large single-port synchronous RAM with one bidirectional (tri-state) data bus.

---
 rtl/ram_pkg.sv | 9 +
 rtl/ram_bank.sv | 23 ++
 rtl/single_port_sync_ram_lg.sv | 60 ++++++
 tb/tb_single_port_sync_ram_lg.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared sizing constants and the word type for the banked single-port RAM.
package ram_pkg;
  localparam int RAM_ADDR_W     = 14;
  localparam int RAM_DATA_W     = 16;
  localparam int RAM_NUM_BANKS  = 4;
  localparam int RAM_BANK_SEL_W = 2;

  typedef logic [RAM_DATA_W-1:0] ram_word_t;
endpackage

// File: rtl/ram_bank.sv
// One quarter of the RAM: a plain synchronous array with a registered read port.
module ram_bank #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-3:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // the top level masks rdata to zero after reset instead.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/single_port_sync_ram_lg.sv
// 4-bank single-port synchronous RAM with a registered read and a tri-state data bus.
module single_port_sync_ram_lg
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  chip_select,
  input  logic                  write_enable,
  input  logic                  output_enable
);
  logic [RAM_BANK_SEL_W-1:0] bank;
  logic [ADDR_WIDTH-3:0]     offset;
  logic [RAM_BANK_SEL_W-1:0] bank_q;
  logic                      rd_valid;
  logic [DATA_WIDTH-1:0]     rd_q;
  logic [DATA_WIDTH-1:0]     bank_rdata [RAM_NUM_BANKS];
  logic                      wr_req;
  logic                      rd_req;

  assign bank   = addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign offset = addr[ADDR_WIDTH-3:0];
  assign wr_req = chip_select & write_enable;
  assign rd_req = chip_select & ~write_enable;

  for (genvar g = 0; g < RAM_NUM_BANKS; g++) begin : g_bank
    ram_bank #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk  (clk),
      .we   (wr_req & (bank == RAM_BANK_SEL_W'(g))),
      .re   (rd_req & (bank == RAM_BANK_SEL_W'(g))),
      .addr (offset),
      .wdata(data),
      .rdata(bank_rdata[g])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q   <= '0;
      rd_valid <= 1'b0;
    end else if (rd_req) begin
      bank_q   <= bank;
      rd_valid <= 1'b1;
    end
  end

  // rd_valid stands in for an async clear of the un-resettable bank read registers.
  assign rd_q = rd_valid ? bank_rdata[bank_q] : '0;

  assign data = (chip_select & output_enable & ~write_enable) ? rd_q : 'z;
endmodule

// File: tb/tb_single_port_sync_ram_lg.sv
// Scoreboard bench for single_port_sync_ram_lg: a shadow memory predicts read data.
module tb_single_port_sync_ram_lg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] addr;
  wire  [15:0] data;
  logic        chip_select;
  logic        write_enable;
  logic        output_enable;
  logic [15:0] tb_data;
  logic        tb_drv;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model [int];
  logic [15:0] sb [$];
  bit          pending = 1'b0;

  assign data = tb_drv ? tb_data : 'z;

  always #5 clk = ~clk;

  single_port_sync_ram_lg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data         (data),
    .chip_select  (chip_select),
    .write_enable (write_enable),
    .output_enable(output_enable)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Compare the read result launched in the previous cycle, if any.
  task automatic drain();
    logic [15:0] exp;
    if (pending) begin
      exp = sb.pop_front();
      check("read", data, exp);
      pending = 1'b0;
    end
  endtask

  // One clock cycle: inputs change on negedge, one full posedge follows.
  task automatic step(input logic cs, input logic we, input logic oe,
                      input logic [13:0] a, input logic [15:0] wd, input logic drv);
    drain();
    chip_select   = cs;
    write_enable  = we;
    output_enable = oe;
    addr          = a;
    tb_data       = wd;
    tb_drv        = drv;
    if (cs && we) model[int'(a)] = wd;
    if (cs && !we && oe) begin
      sb.push_back(model[int'(a)]);
      pending = 1'b1;
    end
    @(posedge clk);
    #1;
    if (drv) check("bus_no_drive", data, wd);
    @(negedge clk);
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] wd, input logic oe);
    step(1'b1, 1'b1, oe, a, wd, 1'b1);
  endtask

  task automatic rd(input logic [13:0] a);
    step(1'b1, 1'b0, 1'b1, a, 16'h0000, 1'b0);
  endtask

  logic [13:0] quad_addr [16];

  initial begin
    rst_n         = 1'b0;
    chip_select   = 1'b1;
    write_enable  = 1'b0;
    output_enable = 1'b1;
    addr          = '0;
    tb_data       = '0;
    tb_drv        = 1'b0;
    #12;
    check("reset_state", data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back write then read of address 0
    wr(14'd0, 16'h1234, 1'b0);
    rd(14'd0);

    // Quadrant boundary writes with random data, then back-to-back reads
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 4; k++)
        quad_addr[q*4+k] = 14'((q + 1) * 4096 - 4 + k);
    for (int i = 0; i < 16; i++) wr(quad_addr[i], 16'($urandom), 1'b1);
    for (int i = 0; i < 16; i++) rd(quad_addr[i]);

    // Bank isolation across the 4095/4096 boundary
    wr(14'd4095, 16'hAAAA, 1'b1);
    wr(14'd4096, 16'h5555, 1'b1);
    rd(14'd4095);
    rd(14'd4096);

    // Deselect hold: writes with chip_select low are ignored and the bus stays ours
    rd(14'd4095);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 14'd4095, 16'h0000, 1'b1);
    rd(14'd4095);

    // Read with output_enable low: bench keeps the bus at zero without contention
    step(1'b1, 1'b0, 1'b0, 14'd4096, 16'h0000, 1'b1);

    // Asynchronous reset between edges clears the bus immediately
    rd(14'd4095);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", data, 16'h0000);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_hold", data, 16'h0000);
    @(negedge clk);
    rd(14'd4096);
    step(1'b0, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0);
    drain();

    if (sb.size() != 0) check("sb_empty", 16'(sb.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
